packet_sender: RTL

Serial packet transmitter for the USB-style link; the transmit-side counterpart of the packet receive datapath. It takes a PID and an optional 64-bit payload and serializes them onto the DP/DM pair. The serial stream is SYNC, PID byte, payload, CRC16 and EOP, with bit stuffing and NRZI encoding. It sits between the top-level protocol FSM, which issues `start`, and the bus drivers.

---
 rtl/packet_sender.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/packet_sender.sv
// Serial packet transmitter: SYNC, PID, optional 64-bit payload + CRC16, EOP, with bit stuffing and NRZI.
// Optional feature: define PACKET_SENDER_CRC_INJECT_EN to add crc_err_inject (corrupts the last CRC bit).
module packet_sender (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        start,
  input  logic [3:0]  pid,
  input  logic        has_data,
  input  logic [63:0] data,
`ifdef PACKET_SENDER_CRC_INJECT_EN
  input  logic        crc_err_inject,
`endif
  output logic        dp,
  output logic        dm,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_PID,
    S_DATA,
    S_CRC,
    S_EOP_SE0,
    S_EOP_J
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // The state names the next bit to be driven, so the bit chosen this cycle
  // lands on dp/dm at the coming edge and SYNC starts right after start.
  state_e      state_q, state_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  ones_q, ones_d;
  logic [15:0] crc_q, crc_d;
  logic [63:0] shift_q, shift_d;
  logic [3:0]  pid_q, pid_d;
  logic        has_data_q, has_data_d;
  logic        line_q, line_d;
  logic        dp_d, dm_d, busy_d, done_d;

  logic        accept;
  logic        tx_bit;
  logic        nrzi_en;
  logic        crc_flip;
  logic        crc_fb;
  logic [15:0] crc_next;

  assign accept   = (state_q == S_IDLE) && start;
  assign crc_fb   = shift_q[63] ^ crc_q[15];
  assign crc_next = {crc_q[14:0], 1'b0} ^ ({16{crc_fb}} & CRC_POLY);

`ifdef PACKET_SENDER_CRC_INJECT_EN
  logic inject_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      inject_q <= 1'b0;
    end else if (accept) begin
      inject_q <= crc_err_inject;
    end
  end

  assign crc_flip = inject_q;
`else
  assign crc_flip = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ones_d     = ones_q;
    crc_d      = crc_q;
    shift_d    = shift_q;
    pid_d      = pid_q;
    has_data_d = has_data_q;
    line_d     = line_q;
    tx_bit     = 1'b1;
    nrzi_en    = 1'b0;
    dp_d       = 1'b1;
    dm_d       = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          pid_d      = pid;
          has_data_d = has_data;
          shift_d    = data;
          crc_d      = CRC_INIT;
          busy_d     = 1'b1;
          nrzi_en    = 1'b1;
          tx_bit     = 1'b0;
          bit_cnt_d  = 7'd1;
          state_d    = S_SYNC;
        end
      end

      S_SYNC: begin
        nrzi_en = 1'b1;
        tx_bit  = (bit_cnt_q == 7'd7);
        if (bit_cnt_q == 7'd7) begin
          bit_cnt_d = 7'd0;
          state_d   = S_PID;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end

      S_PID: begin
        nrzi_en = 1'b1;
        tx_bit  = bit_cnt_q[2] ? ~pid_q[bit_cnt_q[1:0]] : pid_q[bit_cnt_q[1:0]];
        if (bit_cnt_q == 7'd7) begin
          bit_cnt_d = 7'd0;
          ones_d    = 3'd0;
          state_d   = has_data_q ? S_DATA : S_EOP_SE0;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end

      S_DATA: begin
        nrzi_en = 1'b1;
        if (ones_q == 3'd6) begin
          // Stuffed zero: payload position and CRC stand still this cycle.
          tx_bit = 1'b0;
          ones_d = 3'd0;
        end else begin
          tx_bit  = shift_q[63];
          shift_d = {shift_q[62:0], 1'b0};
          crc_d   = crc_next;
          ones_d  = tx_bit ? ones_q + 3'd1 : 3'd0;
          if (bit_cnt_q == 7'd63) begin
            bit_cnt_d = 7'd0;
            state_d   = S_CRC;
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end

      S_CRC: begin
        nrzi_en = 1'b1;
        if (ones_q == 3'd6) begin
          tx_bit = 1'b0;
          ones_d = 3'd0;
          if (bit_cnt_q == 7'd16) begin
            bit_cnt_d = 7'd0;
            state_d   = S_EOP_SE0;
          end
        end else begin
          tx_bit = ~crc_q[4'd15 - bit_cnt_q[3:0]] ^ (crc_flip && (bit_cnt_q == 7'd15));
          ones_d = tx_bit ? ones_q + 3'd1 : 3'd0;
          if (bit_cnt_q == 7'd15) begin
            // Count 16 parks here until the trailing stuffed zero goes out.
            if (ones_d == 3'd6) begin
              bit_cnt_d = 7'd16;
            end else begin
              bit_cnt_d = 7'd0;
              state_d   = S_EOP_SE0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
      end

      S_EOP_SE0: begin
        dp_d   = 1'b0;
        dm_d   = 1'b0;
        line_d = 1'b1;
        if (bit_cnt_q == 7'd1) begin
          bit_cnt_d = 7'd0;
          state_d   = S_EOP_J;
        end else begin
          bit_cnt_d = bit_cnt_q + 7'd1;
        end
      end

      S_EOP_J: begin
        line_d  = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (nrzi_en) begin
      line_d = tx_bit ? line_q : ~line_q;
      dp_d   = line_d;
      dm_d   = ~line_d;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= S_IDLE;
      bit_cnt_q  <= 7'd0;
      ones_q     <= 3'd0;
      crc_q      <= CRC_INIT;
      shift_q    <= 64'd0;
      pid_q      <= 4'd0;
      has_data_q <= 1'b0;
      line_q     <= 1'b1;
      dp         <= 1'b1;
      dm         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_q     <= ones_d;
      crc_q      <= crc_d;
      shift_q    <= shift_d;
      pid_q      <= pid_d;
      has_data_q <= has_data_d;
      line_q     <= line_d;
      dp         <= dp_d;
      dm         <= dm_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
